// File: rtl/square_attack_scanner.sv
// square_attack_scanner: multi-cycle check of whether a square is attacked by any piece of a given colour.
//   clk, rst        clock, asynchronous active-high reset
//   board           64 squares (index row*8+col), each {colour, piece[2:0]}
//                   colour 0=WHITE 1=BLACK; piece 0=EMPTY 1=PAWN 2=KNIGHT 3=BISHOP 4=ROOK 5=QUEEN 6=KING
//   target          square under test, sampled on accepted start
//   attacker_color  colour of attacking pieces, sampled on accepted start
//   start           request, accepted only while busy=0
//   busy            high from the cycle after acceptance through the done cycle
//   done            one-cycle completion pulse
//   attacked        attack_count is nonzero
//   attack_count    saturating number of attackers found
//   first_attacker  square of the first attacker in scan order, 0 if none
//   valid           target held a king of the defending colour at acceptance
module square_attack_scanner #(
    parameter int CNT_W = 4,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0][3:0]      board,
    input  logic [5:0]            target,
    input  logic                  attacker_color,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  attacked,
    output logic [CNT_W-1:0]      attack_count,
    output logic [5:0]            first_attacker,
    output logic                  valid
);
    localparam logic [2:0] EMPTY = 3'd0, PAWN = 3'd1, KNIGHT = 3'd2, BISHOP = 3'd3;
    localparam logic [2:0] ROOK = 3'd4, QUEEN = 3'd5, KING = 3'd6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SHORT, RAY, DONE} state_t;

    // Offsets are {drow, dcol} as 4-bit two's complement; a coordinate
    // stepped off the board always lands in 8..15, so "> 7" means off-board.
    function automatic logic [7:0] knight_off(input logic [2:0] i);
        case (i)
            3'd0: return 8'h21;
            3'd1: return 8'h12;
            3'd2: return 8'hF2;
            3'd3: return 8'hE1;
            3'd4: return 8'hEF;
            3'd5: return 8'hFE;
            3'd6: return 8'h1E;
            default: return 8'h2F;
        endcase
    endfunction

    // N, NE, E, SE, S, SW, W, NW: shared by king offsets and slide rays
    function automatic logic [7:0] dir_off(input logic [2:0] i);
        case (i)
            3'd0: return 8'h10;
            3'd1: return 8'h11;
            3'd2: return 8'h01;
            3'd3: return 8'hF1;
            3'd4: return 8'hF0;
            3'd5: return 8'hFF;
            3'd6: return 8'h0F;
            default: return 8'h1F;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [4:0] b);
        logic [CNT_W+5:0] s;
        s = {6'd0, a} + {{(CNT_W+1){1'b0}}, b};
        return s > {6'd0, CNT_MAX} ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    state_t     state;
    logic [5:0] tgt;
    logic       att_color;
    logic [2:0] dir, pr, pc;
    logic [3:0] tr, tc;

    assign tr = {1'b0, tgt[5:3]};
    assign tc = {1'b0, tgt[2:0]};
    assign attacked = |attack_count;

    // Short-range sources in priority order: 2 pawns, 8 knights, 8 kings
    logic [7:0]  soff [18];
    logic [3:0]  sr [18], sc [18];
    logic [17:0] hit;
    logic [4:0]  pop;
    logic [5:0]  first_hit;

    always_comb begin
        hit = '0;
        pop = '0;
        first_hit = '0;
        for (int i = 0; i < 18; i++) begin
            soff[i] = i < 2  ? {att_color ? 4'h1 : 4'hF, i == 0 ? 4'hF : 4'h1} :
                      i < 10 ? knight_off(3'(i - 2)) : dir_off(3'(i - 10));
            sr[i] = tr + soff[i][7:4];
            sc[i] = tc + soff[i][3:0];
            hit[i] = sr[i] <= 4'd7 && sc[i] <= 4'd7 &&
                     board[{sr[i][2:0], sc[i][2:0]}] == {att_color, i < 2 ? PAWN : i < 10 ? KNIGHT : KING};
            pop = pop + 5'(hit[i]);
        end
        for (int i = 17; i >= 0; i--)
            if (hit[i]) first_hit = {sr[i][2:0], sc[i][2:0]};
    end

    // One step along the current ray
    logic [7:0] rd;
    logic [3:0] nr, nc, np;
    logic [5:0] nsq;
    logic       ray_hit, ray_end;

    always_comb begin
        rd = dir_off(dir);
        nr = {1'b0, pr} + rd[7:4];
        nc = {1'b0, pc} + rd[3:0];
        nsq = {nr[2:0], nc[2:0]};
        np = board[nsq];
        ray_hit = nr <= 4'd7 && nc <= 4'd7 && np[3] == att_color &&
                  (np[2:0] == QUEEN || np[2:0] == (dir[0] ? BISHOP : ROOK));
        // an off-board first step still costs this cycle; the edge square ends the ray
        ray_end = nr > 4'd7 || nc > 4'd7 || np[2:0] != EMPTY ||
                  4'(nr + rd[7:4]) > 4'd7 || 4'(nc + rd[3:0]) > 4'd7;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            attack_count <= '0;
            first_attacker <= '0;
            valid <= 1'b0;
            tgt <= '0;
            att_color <= 1'b0;
            dir <= '0;
            pr <= '0;
            pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // busy still high here means this is the done cycle
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b0;
                    end else if (start) begin
                        busy <= 1'b1;
                        tgt <= target;
                        att_color <= attacker_color;
                        valid <= board[target] == {~attacker_color, KING};
                        attack_count <= '0;
                        first_attacker <= '0;
                        state <= SHORT;
                    end
                end
                SHORT: begin
                    attack_count <= sat_add(attack_count, pop);
                    first_attacker <= first_hit;
                    dir <= '0;
                    pr <= tgt[5:3];
                    pc <= tgt[2:0];
                    state <= EARLY_EXIT && |hit ? DONE : RAY;
                end
                RAY: begin
                    if (ray_hit) begin
                        attack_count <= sat_add(attack_count, 5'd1);
                        if (attack_count == '0) first_attacker <= nsq;
                    end
                    if ((EARLY_EXIT && ray_hit) || (ray_end && dir == 3'd7)) begin
                        state <= DONE;
                    end else if (ray_end) begin
                        dir <= dir + 3'd1;
                        pr <= tgt[5:3];
                        pc <= tgt[2:0];
                    end else begin
                        pr <= nr[2:0];
                        pc <= nc[2:0];
                    end
                end
                default: begin
                    done <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_square_attack_scanner.sv
// tb_square_attack_scanner: checks both EARLY_EXIT variants against a square-walking reference model.
module tb_square_attack_scanner;
    localparam int PN = 1, KN = 2, BI = 3, RK = 4, QN = 5, KG = 6;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, acol = 1'b0;
    logic [5:0] tgt = '0;
    logic [63:0][3:0] bd = '0;
    logic [1:0] bsy, dn, att, vl;
    logic [3:0] cnt [2];
    logic [5:0] fa [2];

    int checks = 0, errors = 0, edges = 0, acc = 0, n_cmp;
    logic [1:0] armed = '0;
    string cur = "";
    int xc [2], xf [2], xl [2], xv;

    square_attack_scanner #(.CNT_W(4), .EARLY_EXIT(1'b0)) u0 (
        .clk(clk), .rst(rst), .board(bd), .target(tgt), .attacker_color(acol), .start(start),
        .busy(bsy[0]), .done(dn[0]), .attacked(att[0]), .attack_count(cnt[0]),
        .first_attacker(fa[0]), .valid(vl[0]));

    square_attack_scanner #(.CNT_W(4), .EARLY_EXIT(1'b1)) u1 (
        .clk(clk), .rst(rst), .board(bd), .target(tgt), .attacker_color(acol), .start(start),
        .busy(bsy[1]), .done(dn[1]), .attacked(att[1]), .attack_count(cnt[1]),
        .first_attacker(fa[1]), .valid(vl[1]));

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference: list short-range attackers in priority order, then walk each
    // ray square by square until something occupies a square or the board ends.
    function automatic void model(input int t, input int col, input int ee,
                                  output int c_o, output int f_o, output int l_o, output int v_o);
        int kr [8] = '{2, 1, -1, -2, -2, -1, 1, 2};
        int kc [8] = '{1, 2, 2, 1, -1, -2, -2, -1};
        int dr [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
        int dc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        int r, c, steps, typ;
        logic cb, stop, blk;
        logic [3:0] p;
        cb = col[0];
        c_o = 0; f_o = 0; l_o = 2; stop = 0;
        v_o = int'(bd[t] == {~cb, 3'(KG)});
        for (int i = 0; i < 18; i++) begin
            if (i < 2) begin r = t / 8 + (cb ? 1 : -1); c = t % 8 + (i == 0 ? -1 : 1); typ = PN; end
            else if (i < 10) begin r = t / 8 + kr[i-2]; c = t % 8 + kc[i-2]; typ = KN; end
            else begin r = t / 8 + dr[i-10]; c = t % 8 + dc[i-10]; typ = KG; end
            if (r >= 0 && r < 8 && c >= 0 && c < 8) begin
                p = bd[r*8+c];
                if (p[3] == cb && int'(p[2:0]) == typ) begin
                    if (c_o == 0) f_o = r * 8 + c;
                    c_o++;
                end
            end
        end
        if (ee != 0 && c_o > 0) stop = 1;
        for (int d = 0; d < 8 && !stop; d++) begin
            r = t / 8; c = t % 8; steps = 0; blk = 0;
            while (!blk) begin
                r += dr[d]; c += dc[d];
                if (r < 0 || r > 7 || c < 0 || c > 7) blk = 1;
                else begin
                    steps++;
                    p = bd[r*8+c];
                    if (p[2:0] != 0) begin
                        blk = 1;
                        if (p[3] == cb && (int'(p[2:0]) == QN || int'(p[2:0]) == (d % 2 == 0 ? RK : BI))) begin
                            if (c_o == 0) f_o = r * 8 + c;
                            c_o++;
                            if (ee != 0) stop = 1;
                        end
                    end
                end
            end
            l_o += steps > 0 ? steps : 1;
        end
        if (c_o > 15) c_o = 15;
    endfunction

    // Per-cycle comparison while a scan is outstanding: n_cmp = clock edges since acceptance
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (armed[k]) begin
                n_cmp = edges - acc;
                if (n_cmp >= 0) begin
                    chk($sformatf("%s u%0d busy@%0d", cur, k, n_cmp), int'(bsy[k]), int'(n_cmp <= xl[k]));
                    chk($sformatf("%s u%0d done@%0d", cur, k, n_cmp), int'(dn[k]), int'(n_cmp == xl[k]));
                    if (n_cmp == xl[k]) begin
                        chk($sformatf("%s u%0d count", cur, k), int'(cnt[k]), xc[k]);
                        chk($sformatf("%s u%0d first", cur, k), int'(fa[k]), xf[k]);
                        chk($sformatf("%s u%0d attacked", cur, k), int'(att[k]), int'(xc[k] > 0));
                        chk($sformatf("%s u%0d valid", cur, k), int'(vl[k]), xv);
                    end
                    if (n_cmp > xl[k]) armed[k] = 1'b0;
                end
            end
        end
    end

    task automatic zero_check(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s u%0d busy", nm, k), int'(bsy[k]), 0);
            chk($sformatf("%s u%0d done", nm, k), int'(dn[k]), 0);
            chk($sformatf("%s u%0d attacked", nm, k), int'(att[k]), 0);
            chk($sformatf("%s u%0d count", nm, k), int'(cnt[k]), 0);
            chk($sformatf("%s u%0d first", nm, k), int'(fa[k]), 0);
            chk($sformatf("%s u%0d valid", nm, k), int'(vl[k]), 0);
        end
    endtask

    task automatic put(input int s, input int col, input int pc);
        bd[s] = {col[0], 3'(pc)};
    endtask

    // mode 0: normal, 1: hold start through the cycle after done, 2: reset mid-ray
    task automatic scan(input string nm, input int t, input int col, input int mode,
                        input int lc0, input int lf0, input int ll0,
                        input int lc1, input int lf1, input int ll1);
        int mc, mf, ml, mv;
        model(t, col, 0, mc, mf, ml, mv);
        xc[0] = mc; xf[0] = mf; xl[0] = ml; xv = mv;
        chk({nm, " model count ee0"}, mc, lc0);
        chk({nm, " model first ee0"}, mf, lf0);
        chk({nm, " model latency ee0"}, ml, ll0);
        model(t, col, 1, mc, mf, ml, mv);
        xc[1] = mc; xf[1] = mf; xl[1] = ml;
        chk({nm, " model count ee1"}, mc, lc1);
        chk({nm, " model first ee1"}, mf, lf1);
        chk({nm, " model latency ee1"}, ml, ll1);
        @(negedge clk);
        cur = nm; tgt = 6'(t); acol = col[0]; start = 1'b1;
        acc = edges + 1; armed = 2'b11;
        @(negedge clk);
        if (mode == 1)
            while (edges - acc < xl[0] + 1) @(negedge clk);
        start = 1'b0;
        if (mode == 2) begin
            repeat (4) @(negedge clk);
            armed = 2'b00;
            rst = 1'b1;
            #1;
            zero_check({nm, " async"});
            @(negedge clk);
            rst = 1'b0;
            repeat (4) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("%s u%0d no done", nm, k), int'(dn[k]), 0);
                    chk($sformatf("%s u%0d idle", nm, k), int'(bsy[k]), 0);
                end
            end
        end else begin
            for (int i = 0; i < 300 && armed != 2'b00; i++) @(negedge clk);
            if (armed != 2'b00) begin
                checks++;
                errors++;
                $display("FAIL %s timeout armed=%b", nm, armed);
                armed = 2'b00;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        zero_check("reset");
        rst = 1'b0;
        @(negedge clk);

        scan("empty", 0, 1, 0, 0, 0, 28, 0, 0, 28);

        bd = '0; put(20, 0, KG); put(29, 1, PN);
        scan("bpawn", 20, 1, 0, 1, 29, 25, 1, 29, 2);

        bd = '0; put(20, 0, KG); put(16, 1, RK); put(18, 0, PN);
        scan("blocked", 20, 1, 0, 0, 0, 25, 0, 0, 25);
        bd[18] = '0;
        scan("rook", 20, 1, 0, 1, 16, 27, 1, 16, 23);

        bd = '0; put(20, 0, KG); put(37, 1, KN); put(60, 1, RK);
        scan("kn_rook", 20, 1, 0, 2, 37, 27, 1, 37, 2);
        scan("reset_mid", 20, 1, 2, 2, 37, 27, 1, 37, 2);
        scan("after_rst", 20, 1, 0, 2, 37, 27, 1, 37, 2);

        bd = '0;
        put(34, 1, PN); put(36, 1, PN);
        foreach (bd[s]) if (s == 44 || s == 37 || s == 21 || s == 12 || s == 10 || s == 17 || s == 33 || s == 42) put(s, 1, KN);
        foreach (bd[s]) if (s == 35 || s == 28 || s == 20 || s == 19 || s == 18 || s == 26) put(s, 1, KG);
        scan("saturate", 27, 1, 0, 15, 34, 10, 15, 34, 2);

        bd = '0;
        scan("hold_start", 0, 1, 1, 0, 0, 28, 0, 0, 28);

        bd = '0; put(63, 1, BI); put(3, 1, KN); put(7, 1, RK);
        scan("diag", 0, 1, 0, 1, 63, 24, 1, 63, 16);

        bd = '0; put(20, 1, KG); put(29, 0, PN);
        scan("wpawn_up", 20, 0, 0, 0, 0, 25, 0, 0, 25);
        put(11, 0, PN);
        scan("wpawn", 20, 0, 0, 1, 11, 24, 1, 11, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
